// File: rtl/codec_playback_scheduler_pkg.sv
// Shared types and defaults for the codec playback scheduler and its sample FIFO.
package codec_playback_scheduler_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  typedef enum logic {
    ZERO = 1'b0,
    HOLD = 1'b1
  } underrun_policy_e;

  function automatic underrun_policy_e policy_from_int(input int hold);
    return (hold != 0) ? HOLD : ZERO;
  endfunction

endpackage

// File: rtl/codec_playback_scheduler_sample_fifo.sv
// Synchronous show-ahead FIFO; dout is always the head entry, valid when !empty.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is reset on purpose so a mid-stream reset cannot leak stale
  // audio; a FIFO that tolerates garbage would leave mem out of the reset branch.
  // NOTE: state updates use <= so every flop samples pre-edge values regardless
  // of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/codec_playback_scheduler.sv
// Feeds buffered stereo samples to the codec, changing pcm_* only in the
// cycle playback_accept rises; handles underrun, mute and underrun counting.
module codec_playback_scheduler
  import codec_playback_scheduler_pkg::*;
#(
  parameter int WIDTH         = SAMPLE_W,
  parameter int DEPTH         = FIFO_DEPTH,
  parameter int UNDERRUN_HOLD = 1,
  parameter int CNT_W         = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_right,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mute,
  input  logic             playback_accept,
  output logic [WIDTH-1:0] pcm_left,
  output logic [WIDTH-1:0] pcm_right,
  output logic             frame_tick,
  output logic [LW-1:0]    level,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_count
);

  localparam underrun_policy_e POLICY = policy_from_int(UNDERRUN_HOLD);

  logic                 accept_prev;
  logic                 armed;
  logic                 frame_edge;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*WIDTH-1:0]   fifo_dout;
  logic [2*WIDTH-1:0]   held;
  logic [2*WIDTH-1:0]   next_sample;

  sample_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({in_left, in_right}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Ready comes from the registered level only: no ready-from-pop path.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  // armed masks the first cycle after reset so an already-high accept is not an edge.
  assign frame_edge = playback_accept & ~accept_prev & armed;
  assign pop        = frame_edge & ~fifo_empty;
  assign frame_tick = frame_edge;
  assign underrun   = frame_edge & fifo_empty;

  // NOTE: next_sample gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    next_sample = '0;
    if (mute) begin
      next_sample = '0;
    end else if (!fifo_empty) begin
      next_sample = fifo_dout;
    end else if (POLICY == HOLD) begin
      next_sample = held;
    end
  end

  assign {pcm_left, pcm_right} = frame_edge ? next_sample : held;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accept_prev    <= 1'b0;
      armed          <= 1'b0;
      held           <= '0;
      underrun_count <= '0;
    end else begin
      accept_prev <= playback_accept;
      armed       <= 1'b1;
      if (frame_edge) held <= next_sample;
      if (underrun && (underrun_count != '1)) underrun_count <= underrun_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_codec_playback_scheduler.sv
// Bench for codec_playback_scheduler: hold and zero underrun variants driven in parallel,
// checked every cycle against a queue-based model plus directed literal expectations.
module tb_codec_playback_scheduler;
  import codec_playback_scheduler_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_valid = 1'b0;
  logic        mute = 1'b0;
  logic        playback_accept = 1'b0;

  logic        in_ready_h, in_ready_z;
  logic [15:0] pcm_left_h, pcm_right_h, pcm_left_z, pcm_right_z;
  logic        frame_tick_h, frame_tick_z;
  logic [2:0]  level_h, level_z;
  logic        underrun_h, underrun_z;
  logic [7:0]  count_h, count_z;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  codec_playback_scheduler #(.WIDTH(16), .DEPTH(DEPTH), .UNDERRUN_HOLD(1), .CNT_W(8)) dut_hold (
    .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready_h), .mute(mute),
    .playback_accept(playback_accept), .pcm_left(pcm_left_h), .pcm_right(pcm_right_h),
    .frame_tick(frame_tick_h), .level(level_h), .underrun(underrun_h),
    .underrun_count(count_h)
  );

  codec_playback_scheduler #(.WIDTH(16), .DEPTH(DEPTH), .UNDERRUN_HOLD(0), .CNT_W(8)) dut_zero (
    .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready_z), .mute(mute),
    .playback_accept(playback_accept), .pcm_left(pcm_left_z), .pcm_right(pcm_right_z),
    .frame_tick(frame_tick_z), .level(level_z), .underrun(underrun_z),
    .underrun_count(count_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model: a queue of pending samples, the last presented sample
  // per policy, and an underrun tally; evaluated at each negedge.
  stereo_t q[$];
  stereo_t held_h, held_z;
  int      cnt;
  bit      prev_m, armed_m;

  initial begin : model
    stereo_t sel_h, sel_z, exp_h, exp_z;
    bit edge_m, emp, full_m;
    held_h = '0; held_z = '0; cnt = 0; prev_m = 0; armed_m = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        held_h = '0; held_z = '0; cnt = 0; prev_m = 0; armed_m = 0;
        check("rst_pcm_h", {pcm_left_h, pcm_right_h}, 32'h0);
        check("rst_pcm_z", {pcm_left_z, pcm_right_z}, 32'h0);
        check("rst_level", level_h, 0);
        check("rst_ready", in_ready_h, 1);
        check("rst_tick", frame_tick_h, 0);
        check("rst_count", count_h, 0);
      end else begin
        edge_m = playback_accept && !prev_m && armed_m;
        emp    = (q.size() == 0);
        full_m = (q.size() == DEPTH);
        if (mute) begin
          sel_h = '0; sel_z = '0;
        end else if (!emp) begin
          sel_h = q[0]; sel_z = q[0];
        end else begin
          sel_h = held_h; sel_z = '0;
        end
        exp_h = edge_m ? sel_h : held_h;
        exp_z = edge_m ? sel_z : held_z;
        check("pcm_h", {pcm_left_h, pcm_right_h}, exp_h);
        check("pcm_z", {pcm_left_z, pcm_right_z}, exp_z);
        check("frame_tick", frame_tick_h, edge_m);
        check("frame_tick_z", frame_tick_z, edge_m);
        check("level", level_h, q.size());
        check("level_z", level_z, q.size());
        check("in_ready", in_ready_h, !full_m);
        check("underrun", underrun_h, edge_m && emp);
        check("underrun_z", underrun_z, edge_m && emp);
        check("count", count_h, cnt);
        check("count_z", count_z, cnt);
        if (edge_m) begin
          held_h = sel_h;
          held_z = sel_z;
          if (!emp) void'(q.pop_front());
          else if (cnt < 255) cnt++;
        end
        if (in_valid && !full_m) q.push_back({in_left, in_right});
        prev_m  = playback_accept;
        armed_m = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    in_valid = 1'b1; in_left = l; in_right = r;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic quick_edge();
    playback_accept = 1'b1;
    tick();
    playback_accept = 1'b0;
    tick();
  endtask

  // Remainder of a 32-cycle frame after the edge cycle (accept high 16, low 16).
  task automatic frame_rest();
    repeat (15) tick();
    playback_accept = 1'b0;
    repeat (16) tick();
  endtask

  initial begin : stimulus
    // Reset state
    repeat (3) tick();
    check("init_pcm_l", pcm_left_h, 16'h0);
    check("init_level", level_h, 0);
    check("init_ready", in_ready_h, 1);
    check("init_count", count_h, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Two samples, 32-cycle frames
    push(16'h1111, 16'h2222);
    push(16'h3333, 16'h4444);
    check("two_pushed_level", level_h, 2);
    playback_accept = 1'b1; #1;
    check("edge1_left", pcm_left_h, 16'h1111);
    check("edge1_right", pcm_right_h, 16'h2222);
    check("edge1_tick", frame_tick_h, 1);
    tick();
    check("post_edge1_tick", frame_tick_h, 0);
    frame_rest();
    check("hold_between_edges", pcm_left_h, 16'h1111);
    playback_accept = 1'b1; #1;
    check("edge2_left", pcm_left_h, 16'h3333);
    check("edge2_right", pcm_right_h, 16'h4444);
    check("edge2_level", level_h, 1);
    tick();
    frame_rest();

    // Fill to DEPTH, reject a fifth, one edge frees a slot
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_left  = (i == DEPTH-1) ? 16'h7FFF : 16'(16'h0100 * (i + 1));
      in_right = in_left;
      tick();
    end
    in_left = 16'hDEAD; in_right = 16'hBEEF;
    check("full_level", level_h, 4);
    check("full_ready", in_ready_h, 0);
    tick();
    check("fifth_rejected", level_h, 4);
    in_valid = 1'b0;
    quick_edge();
    check("after_pop_level", level_h, 3);
    check("after_pop_ready", in_ready_h, 1);
    repeat (3) quick_edge();
    check("drained", level_h, 0);

    // Underrun: hold repeats 0x7FFF, zero policy outputs 0
    for (int k = 0; k < 2; k++) begin
      playback_accept = 1'b1; #1;
      check("ur_hold_pcm", pcm_left_h, 16'h7FFF);
      check("ur_zero_pcm", pcm_left_z, 16'h0000);
      check("ur_pulse", underrun_h, 1);
      tick();
      playback_accept = 1'b0;
      tick();
    end
    check("ur_count_h", count_h, 2);
    check("ur_count_z", count_z, 2);

    // Mute mid-frame with two queued samples
    push(16'h1234, 16'h1234);
    push(16'h5678, 16'h5678);
    tick();
    mute = 1'b1;
    tick();
    check("mute_midframe_pcm", pcm_left_h, 16'h7FFF);
    playback_accept = 1'b1; #1;
    check("mute_edge_pcm", pcm_left_h, 16'h0000);
    tick();
    check("mute_level", level_h, 1);
    playback_accept = 1'b0;
    mute = 1'b0;
    repeat (2) tick();
    playback_accept = 1'b1; #1;
    check("unmute_pcm", pcm_left_h, 16'h5678);
    tick();
    check("unmute_level", level_h, 0);
    playback_accept = 1'b0;
    tick();

    // Saturation
    repeat (300) quick_edge();
    check("sat_count_h", count_h, 255);
    check("sat_count_z", count_z, 255);

    // Reset mid-frame with level 3, pcm 0x5555, accept held high across release
    push(16'h5555, 16'h5555);
    push(16'h6666, 16'h6666);
    push(16'h7777, 16'h7777);
    push(16'h1357, 16'h1357);
    playback_accept = 1'b1;
    tick();
    tick();
    check("pre_reset_pcm", pcm_left_h, 16'h5555);
    check("pre_reset_level", level_h, 3);
    reset_n = 1'b0; #1;
    check("async_rst_pcm", pcm_left_h, 16'h0000);
    check("async_rst_level", level_h, 0);
    check("async_rst_ready", in_ready_h, 1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("no_tick_after_release", frame_tick_h, 0);
      tick();
    end
    playback_accept = 1'b0;
    tick();
    playback_accept = 1'b1; #1;
    check("tick_after_reedge", frame_tick_h, 1);
    tick();
    playback_accept = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_left  = 16'($urandom);
      in_right = 16'($urandom);
      mute     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) playback_accept = ~playback_accept;
      reset_n  = !(c >= 1500 && c < 1502);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
